// File: rtl/nios_system_onchip_memory_arbiter.sv
// Two-port Avalon-MM arbiter sharing the single-port on-chip RAM between Nios II data (p0) and DMA (p1).
// Latency: command grant is combinational; read data returns one cycle after acceptance with readdatavalid.
// Backpressure: losing or idle port sees waitrequest=1; reset/reset_req block all new grants.
module nios_system_onchip_memory_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [BE_W-1:0]   p0_byteenable,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic              p0_waitrequest,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_readdatavalid,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [BE_W-1:0]   p1_byteenable,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic              p1_waitrequest,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  // IDLE: no read in flight; RDATA: RAM is returning data for the read granted last cycle
  typedef enum logic {IDLE = 1'b0, RDATA = 1'b1} rd_state_e;

  rd_state_e state_q, state_d;
  logic      rd_owner_q, rd_owner_d;
  logic      last_grant_q, last_grant_d;

  logic req0, req1, blk;
  logic gnt0, gnt1, gnt_any, gnt_sel;
  logic sel_read, sel_write, rd_gnt;
  logic rd_pending;

  assign req0 = p0_read | p0_write;
  assign req1 = p1_read | p1_write;
  assign blk  = reset | reset_req;

  // Arbitration: single requester wins outright; ties go by priority mode
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!blk) begin
      if (req0 && req1) begin
        if (PRIO_MODE != 0) begin
          gnt0 = 1'b1;
        end else if (last_grant_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign gnt_sel   = gnt1;
  // A port asserting read and write together is treated as writing
  assign sel_write = gnt_sel ? p1_write : p0_write;
  assign sel_read  = gnt_sel ? p1_read  : p0_read;
  assign rd_gnt    = gnt_any & sel_read & ~sel_write;

  // State register for the read tracker and the round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_owner_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rd_owner_q   <= rd_owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state: a granted read occupies the next cycle, anything else empties the pipe
  always_comb begin
    state_d      = rd_gnt ? RDATA : IDLE;
    rd_owner_d   = rd_gnt ? gnt_sel : 1'b0;
    last_grant_d = gnt_any ? gnt_sel : last_grant_q;
  end

  // Outputs: command mux toward the RAM and per-port handshakes back to the masters
  always_comb begin
    rd_pending       = (state_q == RDATA);
    // reset suppresses a response whose read was accepted just before reset rose
    p0_readdatavalid = rd_pending & ~rd_owner_q & ~reset;
    p1_readdatavalid = rd_pending &  rd_owner_q & ~reset;
    p0_readdata      = mem_readdata;
    p1_readdata      = mem_readdata;
    p0_waitrequest   = ~gnt0;
    p1_waitrequest   = ~gnt1;
    mem_address      = gnt_sel ? p1_address    : p0_address;
    mem_byteenable   = gnt_sel ? p1_byteenable : p0_byteenable;
    mem_writedata    = gnt_sel ? p1_writedata  : p0_writedata;
    mem_chipselect   = gnt_any;
    mem_write        = gnt_any & sel_write;
    mem_clken        = 1'b1;
  end

endmodule

// File: tb/tb_nios_system_onchip_memory_arbiter.sv
module tb_nios_system_onchip_memory_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk, reset, reset_req;
  logic [AW-1:0] p0_address, p1_address;
  logic [BW-1:0] p0_byteenable, p1_byteenable;
  logic          p0_read, p1_read, p0_write, p1_write;
  logic [DW-1:0] p0_writedata, p1_writedata;

  logic          p0_waitrequest, p1_waitrequest, p0_readdatavalid, p1_readdatavalid;
  logic [DW-1:0] p0_readdata, p1_readdata, mem_writedata, mem_readdata;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;

  logic          fp_p0_waitrequest, fp_p1_waitrequest, fp_p0_readdatavalid, fp_p1_readdatavalid;
  logic [DW-1:0] fp_p0_readdata, fp_p1_readdata, fp_mem_writedata, fp_mem_readdata;
  logic [AW-1:0] fp_mem_address;
  logic [BW-1:0] fp_mem_byteenable;
  logic          fp_mem_chipselect, fp_mem_write, fp_mem_clken;

  int checks;
  int errors;

  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] ram_fp [0:(1<<AW)-1];

  nios_system_onchip_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read), .p0_write(p0_write),
    .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
    .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read), .p1_write(p1_write),
    .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
    .p1_readdatavalid(p1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  nios_system_onchip_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read), .p0_write(p0_write),
    .p0_writedata(p0_writedata), .p0_waitrequest(fp_p0_waitrequest), .p0_readdata(fp_p0_readdata),
    .p0_readdatavalid(fp_p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read), .p1_write(p1_write),
    .p1_writedata(p1_writedata), .p1_waitrequest(fp_p1_waitrequest), .p1_readdata(fp_p1_readdata),
    .p1_readdatavalid(fp_p1_readdatavalid),
    .mem_address(fp_mem_address), .mem_byteenable(fp_mem_byteenable), .mem_chipselect(fp_mem_chipselect),
    .mem_write(fp_mem_write), .mem_writedata(fp_mem_writedata), .mem_clken(fp_mem_clken),
    .mem_readdata(fp_mem_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM with registered address: data for an address latched at edge N is driven during cycle N..N+1
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  always @(posedge clk) begin
    if (fp_mem_chipselect && fp_mem_clken) begin
      if (fp_mem_write) begin
        for (int b = 0; b < BW; b++)
          if (fp_mem_byteenable[b]) ram_fp[fp_mem_address][8*b +: 8] <= fp_mem_writedata[8*b +: 8];
      end else begin
        fp_mem_readdata <= ram_fp[fp_mem_address];
      end
    end
  end

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {18'h0, a};
  endfunction

  task automatic idle();
    p0_read = 1'b0; p0_write = 1'b0; p0_address = '0; p0_byteenable = 4'hF; p0_writedata = '0;
    p1_read = 1'b0; p1_write = 1'b0; p1_address = '0; p1_byteenable = 4'hF; p1_writedata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    reset_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      reset = 1'b1;
      p0_read = 1'b1; p0_address = 14'h0010;
      p1_read = 1'b1; p1_address = 14'h3FFF;
      #1;
      checks++;
      if (p0_waitrequest !== 1'b1 || p1_waitrequest !== 1'b1) begin
        errors++; $display("FAIL reset_waitrequest got p0=%b p1=%b exp 1 1", p0_waitrequest, p1_waitrequest);
      end
      checks++;
      if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b1) begin
        errors++; $display("FAIL reset_mem got cs=%b wr=%b clken=%b exp 0 0 1", mem_chipselect, mem_write, mem_clken);
      end
      checks++;
      if (p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b0) begin
        errors++; $display("FAIL reset_rdv got p0=%b p1=%b exp 0 0", p0_readdatavalid, p1_readdatavalid);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (p0_waitrequest !== 1'b0 || p1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL first_tie got p0_wait=%b p1_wait=%b exp 0 1", p0_waitrequest, p1_waitrequest);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (p0_readdatavalid !== 1'b1 || p1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL first_tie_rdv got p0=%b p1=%b exp 1 0", p0_readdatavalid, p1_readdatavalid);
    end
  endtask

  task automatic test_single_port();
    do_reset();
    @(negedge clk);
    p0_write = 1'b1; p0_address = 14'h0010; p0_writedata = 32'hDEADBEEF; p0_byteenable = 4'hF;
    #1;
    checks++;
    if (p0_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_chipselect !== 1'b1 || mem_address !== 14'h0010) begin
      errors++; $display("FAIL sp_write got wait=%b wr=%b cs=%b addr=%h exp 0 1 1 0010",
                         p0_waitrequest, mem_write, mem_chipselect, mem_address);
    end
    @(negedge clk);
    p0_write = 1'b0; p0_read = 1'b1;
    #1;
    checks++;
    if (p0_waitrequest !== 1'b0 || mem_write !== 1'b0 || p0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL sp_read_cmd got wait=%b wr=%b rdv=%b exp 0 0 0", p0_waitrequest, mem_write, p0_readdatavalid);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'hDEADBEEF || p1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL sp_read_data got rdv0=%b data=%h rdv1=%b exp 1 deadbeef 0",
                         p0_readdatavalid, p0_readdata, p1_readdatavalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (p0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL sp_rdv_drop got %b exp 0", p0_readdatavalid);
    end
  endtask

  task automatic test_byte_lanes();
    do_reset();
    @(negedge clk);
    p1_write = 1'b1; p1_address = 14'h3FFF; p1_writedata = 32'h11223344; p1_byteenable = 4'hF;
    @(negedge clk);
    p1_writedata = 32'hAABBCCDD; p1_byteenable = 4'h5;
    @(negedge clk);
    p1_write = 1'b0; p1_read = 1'b1;
    #1;
    checks++;
    if (p1_waitrequest !== 1'b0 || mem_address !== 14'h3FFF) begin
      errors++; $display("FAIL bl_read_cmd got wait=%b addr=%h exp 0 3fff", p1_waitrequest, mem_address);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (p1_readdatavalid !== 1'b1 || p1_readdata !== 32'h11BB33DD || p0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL bl_data got rdv1=%b data=%h rdv0=%b exp 1 11bb33dd 0",
                         p1_readdatavalid, p1_readdata, p0_readdatavalid);
    end
  endtask

  task automatic test_contention();
    int i0, i1, exp_g, prev_g, done;
    logic [AW-1:0] prev_a;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      p0_write = 1'b1; p0_byteenable = 4'hF;
      p0_address = (a < 4) ? 14'(a) : 14'(32'h100 + a - 4);
      p0_writedata = pat(p0_address);
    end
    do_reset();
    i0 = 0; i1 = 0; prev_g = -1; prev_a = '0; done = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      p0_read = (i0 < 4); p0_address = 14'(i0);
      p1_read = (i1 < 4); p1_address = 14'(32'h100 + i1);
      #1;
      checks++;
      if (p0_readdatavalid !== (prev_g == 0) || p1_readdatavalid !== (prev_g == 1)) begin
        errors++; $display("FAIL cont_rdv cyc %0d got p0=%b p1=%b exp owner %0d", c, p0_readdatavalid,
                           p1_readdatavalid, prev_g);
      end
      if (prev_g >= 0) begin
        checks++;
        if ((prev_g == 0 ? p0_readdata : p1_readdata) !== pat(prev_a)) begin
          errors++; $display("FAIL cont_data cyc %0d got %h exp %h", c,
                             (prev_g == 0 ? p0_readdata : p1_readdata), pat(prev_a));
        end
        if (p0_readdatavalid | p1_readdatavalid) done++;
      end
      exp_g = (c < 8) ? (c % 2) : -1;
      checks++;
      if (p0_waitrequest !== (exp_g != 0) || p1_waitrequest !== (exp_g != 1)) begin
        errors++; $display("FAIL cont_grant cyc %0d got wait0=%b wait1=%b exp grant %0d", c,
                           p0_waitrequest, p1_waitrequest, exp_g);
      end
      prev_g = exp_g;
      if (exp_g == 0) begin prev_a = p0_address; i0++; end
      if (exp_g == 1) begin prev_a = p1_address; i1++; end
    end
    checks++;
    if (done != 8) begin
      errors++; $display("FAIL cont_completions got %0d exp 8", done);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      p0_read = 1'b1; p0_address = 14'(c);
      p1_read = 1'b1; p1_address = 14'(32'h100 + c);
      #1;
      checks++;
      if (fp_p0_waitrequest !== 1'b0 || fp_p1_waitrequest !== 1'b1) begin
        errors++; $display("FAIL fp_grant cyc %0d got wait0=%b wait1=%b exp 0 1", c, fp_p0_waitrequest, fp_p1_waitrequest);
      end
    end
    @(negedge clk);
    p0_read = 1'b0;
    #1;
    checks++;
    if (fp_p1_waitrequest !== 1'b0 || fp_p0_waitrequest !== 1'b1) begin
      errors++; $display("FAIL fp_p1_after got wait1=%b wait0=%b exp 0 1", fp_p1_waitrequest, fp_p0_waitrequest);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_req();
    do_reset();
    @(negedge clk);
    p0_read = 1'b1; p0_address = 14'h0010;
    #1;
    checks++;
    if (p0_waitrequest !== 1'b0) begin
      errors++; $display("FAIL rr_cmd got wait=%b exp 0", p0_waitrequest);
    end
    @(negedge clk);
    reset_req = 1'b1;
    p1_read = 1'b1; p1_address = 14'h0011;
    #1;
    checks++;
    if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rr_rdv got rdv=%b data=%h exp 1 deadbeef", p0_readdatavalid, p0_readdata);
    end
    checks++;
    if (p0_waitrequest !== 1'b1 || p1_waitrequest !== 1'b1 || mem_chipselect !== 1'b0) begin
      errors++; $display("FAIL rr_block got wait0=%b wait1=%b cs=%b exp 1 1 0", p0_waitrequest, p1_waitrequest, mem_chipselect);
    end
    @(negedge clk);
    #1;
    checks++;
    if (p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL rr_no_rdv got p0=%b p1=%b exp 0 0", p0_readdatavalid, p1_readdatavalid);
    end
    @(negedge clk);
    reset_req = 1'b0;
    idle();
  endtask

  task automatic test_reset_midread();
    do_reset();
    @(negedge clk);
    p1_read = 1'b1; p1_address = 14'h3FFF;
    #1;
    checks++;
    if (p1_waitrequest !== 1'b0) begin
      errors++; $display("FAIL rm_cmd got wait=%b exp 0", p1_waitrequest);
    end
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    checks++;
    if (p1_readdatavalid !== 1'b0 || p0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL rm_rdv got p1=%b p0=%b exp 0 0", p1_readdatavalid, p0_readdatavalid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (p1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL rm_rdv_after got %b exp 0", p1_readdatavalid);
    end
  endtask

  // Random traffic against a transaction-level model: Avalon masters hold a command until accepted,
  // a word-addressed memory map with byte merging, and the arbitration rules as plain decisions.
  task automatic test_random();
    logic [DW-1:0] mdl [int];
    bit            act [2];
    bit            wr [2];
    bit            rdalso [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic [BW-1:0] be [2];
    int            mlast, g, exp_owner;
    logic [DW-1:0] exp_data, cur;
    bit            rq;
    do_reset();
    mlast = 1; exp_owner = -1; exp_data = '0;
    for (int k = 0; k < 2; k++) begin act[k] = 0; wr[k] = 0; rdalso[k] = 0; ad[k] = '0; wd[k] = '0; be[k] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!act[k] && $urandom_range(0, 1) == 1) begin
          act[k] = 1;
          ad[k] = 14'(32'h200 + $urandom_range(0, 7));
          wr[k] = !mdl.exists(int'(ad[k])) || ($urandom_range(0, 1) == 1);
          wd[k] = $urandom;
          be[k] = mdl.exists(int'(ad[k])) ? 4'($urandom_range(1, 15)) : 4'hF;
          rdalso[k] = wr[k] && ($urandom_range(0, 7) == 0);
        end
      end
      rq = (c > 0) && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      reset_req = rq;
      p0_write = act[0] & wr[0]; p0_read = act[0] & (~wr[0] | rdalso[0]);
      p0_address = ad[0]; p0_writedata = wd[0]; p0_byteenable = be[0];
      p1_write = act[1] & wr[1]; p1_read = act[1] & (~wr[1] | rdalso[1]);
      p1_address = ad[1]; p1_writedata = wd[1]; p1_byteenable = be[1];
      #1;
      checks++;
      if (p0_readdatavalid !== (exp_owner == 0) || p1_readdatavalid !== (exp_owner == 1)) begin
        errors++; $display("FAIL rnd_rdv cyc %0d got p0=%b p1=%b exp owner %0d", c, p0_readdatavalid,
                           p1_readdatavalid, exp_owner);
      end
      if (exp_owner >= 0) begin
        checks++;
        if ((exp_owner == 0 ? p0_readdata : p1_readdata) !== exp_data) begin
          errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", c,
                             (exp_owner == 0 ? p0_readdata : p1_readdata), exp_data);
        end
      end
      g = -1;
      if (!rq) begin
        if (act[0] && act[1]) g = (mlast == 0) ? 1 : 0;
        else if (act[0]) g = 0;
        else if (act[1]) g = 1;
      end
      checks++;
      if (p0_waitrequest !== (g != 0) || p1_waitrequest !== (g != 1) || mem_chipselect !== (g >= 0)) begin
        errors++; $display("FAIL rnd_grant cyc %0d got wait0=%b wait1=%b cs=%b exp grant %0d", c,
                           p0_waitrequest, p1_waitrequest, mem_chipselect, g);
      end
      exp_owner = -1;
      if (g >= 0) begin
        checks++;
        if (mem_write !== wr[g] || mem_address !== ad[g]) begin
          errors++; $display("FAIL rnd_cmd cyc %0d got wr=%b addr=%h exp %b %h", c, mem_write, mem_address, wr[g], ad[g]);
        end
        mlast = g;
        if (wr[g]) begin
          cur = mdl.exists(int'(ad[g])) ? mdl[int'(ad[g])] : '0;
          for (int b = 0; b < BW; b++)
            if (be[g][b]) cur[8*b +: 8] = wd[g][8*b +: 8];
          mdl[int'(ad[g])] = cur;
        end else begin
          exp_owner = g;
          exp_data = mdl[int'(ad[g])];
        end
        act[g] = 0;
      end
    end
    @(negedge clk);
    reset_req = 1'b0;
    idle();
    #1;
    checks++;
    if (p0_readdatavalid !== (exp_owner == 0) || p1_readdatavalid !== (exp_owner == 1)) begin
      errors++; $display("FAIL rnd_rdv_tail got p0=%b p1=%b exp owner %0d", p0_readdatavalid, p1_readdatavalid, exp_owner);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    reset_req = 1'b0;
    idle();
    test_reset();
    test_single_port();
    test_byte_lanes();
    test_contention();
    test_fixed_priority();
    test_reset_req();
    test_reset_midread();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
